calc_sequencer: RTL and testbench

//   Operand-entry and execution controller for the 8-bit add/subtract calculator.

---
 rtl/calc_sequencer_if.sv | 27 ++
 rtl/calc_sequencer.sv | 109 ++++++++++
 tb/tb_calc_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// Signal bundle between the calculator sequencer, its button/switch inputs and the adder datapath.
// master = sequencer side; slave = surrounding top-level/datapath side.
interface calc_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             btn_ent;
  logic             btn_op;
  logic [WIDTH-1:0] sw;
  logic [WIDTH:0]   dp_sum;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic [WIDTH-1:0] disp;
  logic             flag;
  logic [1:0]       state;
  logic             done;

  modport master (
    input  btn_ent, btn_op, sw, dp_sum,
    output op_a, op_b, op_sub, disp, flag, state, done
  );

  modport slave (
    output btn_ent, btn_op, sw, dp_sum,
    input  op_a, op_b, op_sub, disp, flag, state, done
  );
endinterface

// File: rtl/calc_sequencer.sv
// Operand entry / execute controller for the add/sub calculator; result SETTLE cycles after B ENTER.
// No backpressure: button edges outside S_A/S_B (OP) or S_EXEC (both) are dropped, never queued.
module calc_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 4
) (
  input logic              CLK,
  input logic              RST_N,
  calc_sequencer_if.master bus
);

  localparam logic [1:0] S_A    = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_EXEC = 2'b10;
  localparam logic [1:0] S_SHOW = 2'b11;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

  logic [1:0]       state_q;
  logic             ent_prev;
  logic             op_prev;
  logic             ent_p;
  logic             op_p;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] result_q;
  logic             op_sub_q;
  logic             flag_q;
  logic             done_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] disp_c;

  // Prev registers reset high so a button held through reset needs a release first.
  assign ent_p = bus.btn_ent & ~ent_prev;
  assign op_p  = bus.btn_op  & ~op_prev;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_A;
      ent_prev <= 1'b1;
      op_prev  <= 1'b1;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      op_sub_q <= 1'b0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ent_prev <= bus.btn_ent;
      op_prev  <= bus.btn_op;
      done_q   <= 1'b0;
      case (state_q)
        S_A: begin
          if (op_p) op_sub_q <= ~op_sub_q;
          if (ent_p) begin
            op_a_q  <= bus.sw;
            state_q <= S_B;
          end
        end
        S_B: begin
          // A simultaneous OP toggle lands in the same edge, so it governs this execution.
          if (op_p) op_sub_q <= ~op_sub_q;
          if (ent_p) begin
            op_b_q  <= bus.sw;
            cnt_q   <= CNT_INIT;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            result_q <= bus.dp_sum[WIDTH-1:0];
            // Subtract carry-out is the inverse of borrow.
            flag_q   <= op_sub_q ? ~bus.dp_sum[WIDTH] : bus.dp_sum[WIDTH];
            done_q   <= 1'b1;
            state_q  <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (ent_p) begin
            flag_q  <= 1'b0;
            state_q <= S_A;
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  always_comb begin
    disp_c = '0;
    case (state_q)
      S_A, S_B: disp_c = bus.sw;
      S_SHOW:   disp_c = result_q;
      default:  disp_c = '0;
    endcase
  end

  assign bus.op_a   = op_a_q;
  assign bus.op_b   = op_b_q;
  assign bus.op_sub = op_sub_q;
  assign bus.disp   = disp_c;
  assign bus.flag   = flag_q;
  assign bus.state  = state_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected {disp, flag} queued at stimulus, checked on done.
module tb_calc_sequencer;

  localparam int W      = 8;
  localparam int SETTLE = 4;

  typedef struct packed {
    logic [W-1:0] disp;
    logic         flag;
  } exp_t;

  logic CLK;
  logic RST_N;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  calc_sequencer_if #(.WIDTH(W)) bus ();

  calc_sequencer #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // Ripple-adder datapath model: sub is op_a + ~op_b + 1.
  assign bus.dp_sum = {1'b0, bus.op_a} + {1'b0, (bus.op_sub ? ~bus.op_b : bus.op_b)}
                      + {{W{1'b0}}, bus.op_sub};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press_ent(input logic [W-1:0] v);
    bus.sw      = v;
    bus.btn_ent = 1'b1;
    tick();
    bus.btn_ent = 1'b0;
    tick();
  endtask

  task automatic press_op();
    bus.btn_op = 1'b1;
    tick();
    bus.btn_op = 1'b0;
    tick();
  endtask

  task automatic wait_show(input string name, input int exp_ticks);
    int n = 0;
    while (bus.state != 2'b11 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(exp_ticks));
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RST_N && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_disp", 32'(bus.disp), 32'(e.disp));
        chk("sb_flag", 32'(bus.flag), 32'(e.flag));
        chk("sb_state", 32'(bus.state), 32'd3);
      end
    end
  end

  initial begin
    RST_N       = 1'b0;
    bus.btn_ent = 1'b1;
    bus.btn_op  = 1'b0;
    bus.sw      = '0;

    // 1: reset with ENTER held
    repeat (3) tick();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_op_a", 32'(bus.op_a), 32'd0);
    chk("rst_op_b", 32'(bus.op_b), 32'd0);
    chk("rst_op_sub", 32'(bus.op_sub), 32'd0);
    chk("rst_flag", 32'(bus.flag), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_disp", 32'(bus.disp), 32'd0);
    RST_N = 1'b1;
    repeat (3) tick();
    chk("held_ent_no_edge", 32'(bus.state), 32'd0);
    bus.btn_ent = 1'b0;
    tick();

    // 2: 100 + 27
    exp_q.push_back('{disp: 8'h7F, flag: 1'b0});
    press_ent(8'h64);
    chk("add_state_b", 32'(bus.state), 32'd1);
    chk("add_op_a", 32'(bus.op_a), 32'h64);
    press_ent(8'h1B);
    chk("add_state_exec", 32'(bus.state), 32'd2);
    chk("exec_disp_zero", 32'(bus.disp), 32'd0);
    // One S_EXEC cycle has already elapsed inside press_ent.
    wait_show("exec_len", SETTLE - 1);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("show_hold_disp", 32'(bus.disp), 32'h7F);
    press_ent(8'h00);
    chk("show_ent_state", 32'(bus.state), 32'd0);

    // 3: 0xFF + 0x02 with carry
    exp_q.push_back('{disp: 8'h01, flag: 1'b1});
    press_ent(8'hFF);
    press_ent(8'h02);
    wait_show("carry_wait", SETTLE - 1);
    chk("carry_flag", 32'(bus.flag), 32'd1);
    press_ent(8'h00);
    chk("carry_back_state", 32'(bus.state), 32'd0);
    chk("carry_flag_clr", 32'(bus.flag), 32'd0);

    // 4: 5 - 9
    press_op();
    chk("op_toggle", 32'(bus.op_sub), 32'd1);
    exp_q.push_back('{disp: 8'hFC, flag: 1'b1});
    press_ent(8'h05);
    press_ent(8'h09);
    wait_show("sub_wait", SETTLE - 1);
    press_op();
    chk("show_op_ignored", 32'(bus.op_sub), 32'd1);
    press_ent(8'h00);

    // 5: ENTER+OP together in S_B, then presses during S_EXEC are dropped
    press_op();
    chk("op_back_add", 32'(bus.op_sub), 32'd0);
    press_ent(8'h10);
    exp_q.push_back('{disp: 8'h0D, flag: 1'b0});
    bus.sw      = 8'h03;
    bus.btn_ent = 1'b1;
    bus.btn_op  = 1'b1;
    tick();
    bus.btn_ent = 1'b0;
    bus.btn_op  = 1'b0;
    tick();
    chk("same_cycle_sub", 32'(bus.op_sub), 32'd1);
    chk("same_cycle_op_b", 32'(bus.op_b), 32'h03);
    bus.btn_ent = 1'b1;
    bus.btn_op  = 1'b1;
    tick();
    bus.btn_ent = 1'b0;
    bus.btn_op  = 1'b0;
    tick();
    chk("exec_ignore_state", 32'(bus.state), 32'd2);
    chk("exec_ignore_op", 32'(bus.op_sub), 32'd1);
    wait_show("ignore_wait", 1);
    press_ent(8'h00);

    // 6: reset during cycle 2 of S_EXEC
    press_ent(8'h11);
    press_ent(8'h22);
    bus.sw = 8'h00;
    RST_N  = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_op_a", 32'(bus.op_a), 32'd0);
    chk("midrst_op_sub", 32'(bus.op_sub), 32'd0);
    chk("midrst_disp", 32'(bus.disp), 32'd0);
    repeat (8) tick();
    chk("midrst_idle", 32'(bus.state), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
